// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Reads return a fixed latency later and are steered back by a tag pipeline.
module memory_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_address,
    input  logic            fetch_flush,
    output logic            fetch_rsp_valid,
    output logic [XLEN-1:0] fetch_rsp_data,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic            data_write_enable,
    input  logic [XLEN-1:0] data_address,
    input  logic [XLEN-1:0] data_write_data,
    output logic            data_rsp_valid,
    output logic [XLEN-1:0] data_rsp_data,
    output logic            mem_valid,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    // Handshake: a request transfers in any cycle where valid && ready; ready is
    // a combinational function of both valids and the streak counter only.

    logic [3:0]              streak;
    logic                    grant_fetch;
    logic                    grant_data;
    logic                    grant_read;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_owner;
    logic [READ_LATENCY-1:0] tag_valid_live;
    logic                    last_valid;

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (!rst) begin
            if (fetch_valid && data_valid) begin
                if (streak == 4'(MAX_DATA_STREAK)) grant_fetch = 1'b1;
                else                               grant_data  = 1'b1;
            end else begin
                grant_fetch = fetch_valid;
                grant_data  = data_valid;
            end
        end
    end

    assign fetch_ready = grant_fetch;
    assign data_ready  = grant_data;
    assign grant_read  = grant_fetch || (grant_data && !data_write_enable);

    always_comb begin
        mem_valid        = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        if (grant_fetch) begin
            mem_valid   = 1'b1;
            mem_address = fetch_address;
        end else if (grant_data) begin
            mem_valid        = 1'b1;
            mem_write_enable = data_write_enable;
            mem_address      = data_address;
            mem_write_data   = data_write_data;
        end
    end

    // A data grant while fetch is waiting is by construction a contended one.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_fetch || !fetch_valid) begin
            streak <= '0;
        end else if (grant_data) begin
            streak <= streak + 4'd1;
        end
    end

    // Flush kills fetch-owned entries in place, so the last stage is covered too.
    assign tag_valid_live = tag_valid & ~({READ_LATENCY{fetch_flush}} & ~tag_owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= grant_read;
            tag_owner[0] <= grant_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid_live[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign last_valid      = tag_valid_live[READ_LATENCY-1] && !rst;
    assign fetch_rsp_valid = last_valid && !tag_owner[READ_LATENCY-1];
    assign data_rsp_valid  = last_valid &&  tag_owner[READ_LATENCY-1];
    assign fetch_rsp_data  = fetch_rsp_valid ? mem_read_data : '0;
    assign data_rsp_data   = data_rsp_valid  ? mem_read_data : '0;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: vector table for grants/memory drive, plus
// directed sequences with a response scoreboard fed by a latency-matched ROM.
module tb_memory_port_arbiter;
  localparam int XLEN = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic            clk;
  logic            rst;
  logic            fetch_valid, fetch_ready, fetch_flush, fetch_rsp_valid;
  logic [XLEN-1:0] fetch_address, fetch_rsp_data;
  logic            data_valid, data_ready, data_write_enable, data_rsp_valid;
  logic [XLEN-1:0] data_address, data_write_data, data_rsp_data;
  logic            mem_valid, mem_write_enable;
  logic [XLEN-1:0] mem_address, mem_write_data, mem_read_data;

  memory_port_arbiter #(.XLEN(XLEN), .READ_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_address(fetch_address),
    .fetch_flush(fetch_flush), .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .data_valid(data_valid), .data_ready(data_ready), .data_write_enable(data_write_enable),
    .data_address(data_address), .data_write_data(data_write_data),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .mem_valid(mem_valid), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: read data is a fixed function of the address, LAT cycles after the read
  function automatic logic [XLEN-1:0] rom(input logic [XLEN-1:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  logic [LAT-1:0]  mline_v;
  logic [XLEN-1:0] mline_a [LAT];
  always @(posedge clk) begin
    mline_v[0] <= mem_valid && !mem_write_enable;
    mline_a[0] <= mem_address;
    for (int i = 1; i < LAT; i++) begin
      mline_v[i] <= mline_v[i-1];
      mline_a[i] <= mline_a[i-1];
    end
  end
  assign mem_read_data = mline_v[LAT-1] ? rom(mline_a[LAT-1]) : 32'hBAD0_0BAD;

  // scoreboard: {due cycle[48:33], owner[32], data[31:0]}
  logic [48:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [XLEN-1:0] addr);
    logic [15:0] due;
    due = 16'(cyc + LAT);
    exp_q.push_back({due, owner, rom(addr)});
  endtask

  task automatic check_rsp();
    logic [48:0]     e;
    logic            e_fv, e_dv;
    logic [XLEN-1:0] e_fd, e_dd;
    e_fv = 1'b0; e_dv = 1'b0; e_fd = '0; e_dd = '0;
    while (exp_q.size() > 0 && int'(exp_q[0][48:33]) < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL rsp_lost: response due cycle %0d never seen (now %0d)", e[48:33], cyc);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][48:33]) == cyc) begin
      e = exp_q.pop_front();
      if (e[32]) begin e_dv = 1'b1; e_dd = e[31:0]; end
      else       begin e_fv = 1'b1; e_fd = e[31:0]; end
    end
    chk1("fetch_rsp_valid", fetch_rsp_valid, e_fv);
    chk("fetch_rsp_data", fetch_rsp_data, e_fd);
    chk1("data_rsp_valid", data_rsp_valid, e_dv);
    chk("data_rsp_data", data_rsp_data, e_dd);
  endtask

  // negedge phase: responses, reset outputs, then record accepted reads
  task automatic sample_phase();
    logic [48:0] keep[$];
    @(negedge clk);
    if (rst) exp_q.delete();
    if (fetch_flush) begin
      keep = {};
      foreach (exp_q[i]) if (exp_q[i][32]) keep.push_back(exp_q[i]);
      exp_q = keep;
    end
    check_rsp();
    if (rst) begin
      chk1("rst_fetch_ready", fetch_ready, 1'b0);
      chk1("rst_data_ready", data_ready, 1'b0);
      chk1("rst_mem_valid", mem_valid, 1'b0);
      chk1("rst_mem_we", mem_write_enable, 1'b0);
    end else begin
      if (fetch_valid && fetch_ready) push_exp(1'b0, fetch_address);
      if (data_valid && data_ready && !data_write_enable) push_exp(1'b1, data_address);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample_phase();
    advance();
  endtask

  task automatic idle(input int n);
    fetch_valid = 1'b0; data_valid = 1'b0; data_write_enable = 1'b0;
    fetch_flush = 1'b0; data_write_data = '0;
    repeat (n) cycle();
  endtask

  typedef struct {
    logic fv, dv, dwe;
    logic [XLEN-1:0] fa, da, dwd;
    logic e_fr, e_dr, e_mv, e_mwe;
    logic [XLEN-1:0] e_ma, e_mwd;
  } vec_t;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b0, 32'h0,    32'h0,    32'h0,    1'b0,1'b0,1'b0,1'b0, 32'h0,    32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0, 32'h1000, 32'h0,    32'h0,    1'b1,1'b0,1'b1,1'b0, 32'h1000, 32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0, 32'h0,    32'h2000, 32'h0,    1'b0,1'b1,1'b1,1'b0, 32'h2000, 32'h0};
    vecs[3]  = '{1'b0,1'b1,1'b1, 32'h0,    32'h2004, 32'hCAFE, 1'b0,1'b1,1'b1,1'b1, 32'h2004, 32'hCAFE};
    vecs[4]  = '{1'b1,1'b1,1'b1, 32'h1004, 32'h2008, 32'h5A5A, 1'b0,1'b1,1'b1,1'b1, 32'h2008, 32'h5A5A};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = vecs[4];
    vecs[8]  = '{1'b1,1'b1,1'b1, 32'h1004, 32'h2008, 32'h5A5A, 1'b1,1'b0,1'b1,1'b0, 32'h1004, 32'h0};
    vecs[9]  = '{1'b1,1'b1,1'b0, 32'h1008, 32'h200C, 32'h0,    1'b0,1'b1,1'b1,1'b0, 32'h200C, 32'h0};
    vecs[10] = '{1'b0,1'b1,1'b0, 32'h0,    32'h2010, 32'h0,    1'b0,1'b1,1'b1,1'b0, 32'h2010, 32'h0};
    vecs[11] = '{1'b1,1'b1,1'b0, 32'h1008, 32'h2014, 32'h0,    1'b0,1'b1,1'b1,1'b0, 32'h2014, 32'h0};
    vecs[12] = '{1'b1,1'b0,1'b0, 32'h1008, 32'h0,    32'h0,    1'b1,1'b0,1'b1,1'b0, 32'h1008, 32'h0};
    vecs[13] = '{1'b1,1'b1,1'b0, 32'h100C, 32'h2018, 32'h0,    1'b0,1'b1,1'b1,1'b0, 32'h2018, 32'h0};

    rst = 1'b1; fetch_flush = 1'b0;
    fetch_valid = 1'b0; fetch_address = '0;
    data_valid = 1'b0; data_write_enable = 1'b0; data_address = '0; data_write_data = '0;
    @(posedge clk); #1;

    // reset held with both requesters valid
    fetch_valid = 1'b1; data_valid = 1'b1; fetch_address = 32'h40; data_address = 32'h80;
    repeat (3) cycle();
    rst = 1'b0;
    idle(2 * LAT);

    // vector table: grants, streak, memory drive
    for (int i = 0; i < 14; i++) begin
      fetch_valid = vecs[i].fv; data_valid = vecs[i].dv; data_write_enable = vecs[i].dwe;
      fetch_address = vecs[i].fa; data_address = vecs[i].da; data_write_data = vecs[i].dwd;
      sample_phase();
      chk1($sformatf("vec%0d_fetch_ready", i), fetch_ready, vecs[i].e_fr);
      chk1($sformatf("vec%0d_data_ready", i), data_ready, vecs[i].e_dr);
      chk1($sformatf("vec%0d_mem_valid", i), mem_valid, vecs[i].e_mv);
      chk1($sformatf("vec%0d_mem_we", i), mem_write_enable, vecs[i].e_mwe);
      chk($sformatf("vec%0d_mem_addr", i), mem_address, vecs[i].e_ma);
      chk($sformatf("vec%0d_mem_wdata", i), mem_write_data, vecs[i].e_mwd);
      advance();
    end
    idle(LAT + 1);

    // single fetch: 0x100 reads back 0xDEADBEEF two cycles later
    fetch_valid = 1'b1; fetch_address = 32'h100;
    cycle();
    idle(LAT + 1);

    // sustained contention: D,D,D,D,F repeating
    for (int k = 0; k < 15; k++) begin
      fetch_valid = 1'b1; data_valid = 1'b1; data_write_enable = 1'b0;
      fetch_address = 32'h3000 + 32'(4 * k); data_address = 32'h4000 + 32'(4 * k);
      sample_phase();
      chk1("t3_fetch_ready", fetch_ready, (k % 5) == 4);
      chk1("t3_data_ready", data_ready, (k % 5) != 4);
      advance();
    end
    idle(LAT + 1);

    // store then load of the same address
    data_valid = 1'b1; data_write_enable = 1'b1; data_address = 32'h200; data_write_data = 32'h55;
    sample_phase();
    chk1("t4_store_we", mem_write_enable, 1'b1);
    chk("t4_store_wdata", mem_write_data, 32'h55);
    chk("t4_store_addr", mem_address, 32'h200);
    advance();
    data_write_enable = 1'b0; data_write_data = '0;
    sample_phase();
    chk1("t4_load_we", mem_write_enable, 1'b0);
    chk1("t4_load_valid", mem_valid, 1'b1);
    advance();
    idle(LAT + 1);

    // flush kills two in-flight fetches; the fetch issued with the flush survives
    fetch_valid = 1'b1; fetch_address = 32'h500; cycle();
    fetch_address = 32'h504; cycle();
    fetch_address = 32'h508; fetch_flush = 1'b1;
    sample_phase();
    chk1("t5_flush_fetch_ready", fetch_ready, 1'b1);
    advance();
    idle(LAT + 1);

    // flush leaves a data read untouched, even in its response cycle
    data_valid = 1'b1; data_address = 32'h600; cycle();
    idle(1);
    fetch_flush = 1'b1; cycle();
    idle(LAT + 1);

    // alternating fetch / load every cycle
    for (int k = 0; k < 12; k++) begin
      fetch_valid = (k % 2) == 0; data_valid = (k % 2) == 1; data_write_enable = 1'b0;
      fetch_address = 32'($urandom_range(0, 16'hFFFF)) << 2;
      data_address  = 32'($urandom_range(0, 16'hFFFF)) << 2;
      cycle();
    end
    idle(LAT + 1);

    // reset in the middle of outstanding reads drops them
    fetch_valid = 1'b1; fetch_address = 32'h700; cycle();
    fetch_valid = 1'b0; data_valid = 1'b1; data_address = 32'h704; cycle();
    data_valid = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0;
    idle(2 * LAT);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
